cbus_rr_arbiter: RTL and testbench
==================================

// Module: cbus_rr_arbiter
// PURPOSE
//  N:1 arbiter for the cached/uncached memory bus (cbus_req_t/cbus_resp_t), sitting between core-side masters and the single memory port.
//  Successor to the fixed-priority arbiter: adds selectable round-robin fairness, an optional starvation guard, grant status outputs
//  and a registered grant index. Each granted transaction is held until oresp.last; other inputs see zero responses meanwhile.
// PARAMETERS
//  NUM_INPUTS    2   number of request ports (>=1)
//  ROUND_ROBIN   1   1: rotating priority starting after last winner; 0: fixed priority, lowest index wins
//  STARVE_LIMIT  0   0: disabled; >0: an input passed over this many consecutive arbitrations is forced to win next
//  IDX_W         $clog2(NUM_INPUTS>1?NUM_INPUTS:2)  localparam, grant index width
// PORTS
//  clk        in   1                   clock, all state on posedge
//  reset      in   1                   synchronous, active-low: reset==0 at posedge clears all state
//  ireqs      in   NUM_INPUTS*cbus_req_t   per-master requests
//  iresps     out  NUM_INPUTS*cbus_resp_t  per-master responses
//  oreq       out  cbus_req_t          request to memory
//  oresp      in   cbus_resp_t         response from memory
//  busy       out  1                   transaction in progress
//  grant_idx  out  IDX_W               index of current owner (valid when busy)
// BEHAVIOUR
//  Reset (reset==0): busy=0, grant_idx=0, rr pointer=0, starvation counters=0; oreq='0, iresps='0 combinationally.
//  States: IDLE, BUSY.
//  IDLE: pick winner among inputs with ireqs[i].valid; if any, next cycle BUSY, grant_idx<=winner. No valid -> stay IDLE.
//   oreq='0 in IDLE (no early issue); one-cycle arbitration latency from valid to oreq.valid.
//  BUSY: oreq=ireqs[grant_idx] passed through live (write data/strobe may change per beat); iresps[grant_idx]=oresp, others '0.
//   oresp.last in BUSY -> IDLE next cycle; back-to-back requests re-arbitrate in that IDLE cycle (1 bubble per transaction).
//   Owner dropping valid before last: still BUSY until last; oreq forwards the dropped valid as is (master protocol violation, not masked).
//   oresp.last while IDLE: ignored.
//  Round-robin: search order ptr, ptr+1, ... ptr+N-1 mod N; on grant ptr<=winner+1 mod N (wraps N-1 -> 0).
//  Fixed: search order 0..N-1; ptr unused.
//  Starvation (STARVE_LIMIT>0): per input, counter increments at each grant to another input while that input is valid; clears
//   when granted or valid low. Counter saturates at STARVE_LIMIT; any saturated input overrides policy (lowest such index wins).
//  Counter width $clog2(STARVE_LIMIT+1); no wrap.
//  NUM_INPUTS==1: always grant 0; ptr and counters are constant 0.
//  Reset asserted mid-BUSY: immediate return to IDLE next edge, oreq drops to '0; memory side must also be reset.
// STRUCTURE
//  Shared package: cbus_req_t/cbus_resp_t (existing), arb_policy_e {ARB_FIXED, ARB_RR} if the mode becomes an enum.
//  Sub-module: rr_pick #(N) - combinational: valid vector + start pointer -> found, index. Reused for fixed mode with ptr=0.
//  Top: FSM, pointer, counters, response demux.
// TESTING
//  1. Reset: hold reset=0 3 cycles with all valid=1 -> busy=0, oreq.valid=0, all iresps=0.
//  2. Single req on port 1 (N=2): valid at cycle t -> oreq.valid at t+1, grant_idx=1; last at t+4 -> busy=0 at t+5.
//  3. RR, N=4, all valid continuously, 1-beat txns -> grant order 0,1,2,3,0,1 with one idle cycle between grants.
//  4. Fixed mode, N=4, ports 0 and 3 continuously valid -> port 0 wins every time; port 3 never granted.
//  5. Fixed, STARVE_LIMIT=2, ports 0,3 continuously valid -> grants 0,0,3,0,0,3.
//  6. 4-beat burst on port 0 while port 1 valid -> iresps[1] stays 0 until after last; port 1 granted next.
//     Also: reset=0 at beat 2 -> idle next cycle.

Source files
------------

// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared cbus request/response types plus the arbiter's policy and state enums.
package cbus_rr_arbiter_pkg;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic        uncached;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] rdata;
  } cbus_resp_t;

  typedef enum logic { ARB_FIXED, ARB_RR } arb_policy_e;
  typedef enum logic { S_IDLE, S_BUSY } arb_state_e;

endpackage

// File: rtl/cbus_rr_arbiter_pick.sv
// Combinational circular priority search: first set bit of req starting at start, wrapping mod N.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N > 1 ? N : 2)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  // Walk from the farthest candidate back to start so the nearest one wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IW'((int'(start) + k) % N);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// N:1 cbus arbiter: round-robin or fixed priority, optional starvation guard,
// ownership held from grant until oresp.last.
module cbus_rr_arbiter
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS   = 2,
  parameter int ROUND_ROBIN  = 1,
  parameter int STARVE_LIMIT = 0,
  localparam int IDX_W = $clog2(NUM_INPUTS > 1 ? NUM_INPUTS : 2)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  cbus_req_t  [NUM_INPUTS-1:0]  ireqs,
  output cbus_resp_t [NUM_INPUTS-1:0]  iresps,
  output cbus_req_t                    oreq,
  input  cbus_resp_t                   oresp,
  output logic                         busy,
  output logic       [IDX_W-1:0]       grant_idx
);

  localparam arb_policy_e POLICY = (ROUND_ROBIN != 0) ? ARB_RR : ARB_FIXED;
  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [IDX_W-1:0] ZERO_IDX = '0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  arb_state_e            state;
  logic [IDX_W-1:0]      ptr, start, pol_idx, sat_idx, winner;
  logic [NUM_INPUTS-1:0] req_vec, sat_vec;
  logic                  pol_found, sat_found, grant;

  always_comb begin
    req_vec = '0;
    for (int i = 0; i < NUM_INPUTS; i++) req_vec[i] = ireqs[i].valid;
  end

  assign start = (POLICY == ARB_RR) ? ptr : ZERO_IDX;

  rr_pick #(.N(NUM_INPUTS), .IW(IDX_W)) u_pol (
    .req(req_vec), .start(start), .found(pol_found), .idx(pol_idx)
  );

  // Starved inputs bypass the policy; lowest starved index wins.
  rr_pick #(.N(NUM_INPUTS), .IW(IDX_W)) u_sat (
    .req(sat_vec), .start(ZERO_IDX), .found(sat_found), .idx(sat_idx)
  );

  assign winner = sat_found ? sat_idx : pol_idx;
  assign grant  = (state == S_IDLE) && pol_found;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      grant_idx <= '0;
      ptr       <= '0;
    end else begin
      case (state)
        S_IDLE: if (pol_found) begin
          state     <= S_BUSY;
          busy      <= 1'b1;
          grant_idx <= winner;
          if (POLICY == ARB_RR && NUM_INPUTS > 1)
            ptr <= (winner == LAST_IDX) ? ZERO_IDX : winner + IDX_W'(1);
        end
        S_BUSY: if (oresp.last) begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  generate
    if (STARVE_LIMIT > 0 && NUM_INPUTS > 1) begin : g_starve
      for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt;
        always_ff @(posedge clk) begin
          if (!reset || !req_vec[i]) begin
            cnt <= '0;
          end else if (grant) begin
            if (winner == IDX_W'(i))                cnt <= '0;
            else if (cnt != CNT_W'(STARVE_LIMIT))   cnt <= cnt + CNT_W'(1);
          end
        end
        assign sat_vec[i] = req_vec[i] && (cnt == CNT_W'(STARVE_LIMIT));
      end
    end else begin : g_no_starve
      assign sat_vec = '0;
    end
  endgenerate

  // Owner's request and the memory response pass through live; reset forces both quiet.
  always_comb begin
    oreq   = '0;
    iresps = '0;
    if (busy && reset) begin
      oreq              = ireqs[grant_idx];
      iresps[grant_idx] = oresp;
    end
  end

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Bench for cbus_rr_arbiter: four configurations, grant order scoreboarded by a negedge monitor.
module tb_cbus_rr_arbiter;
  import cbus_rr_arbiter_pkg::*;

  logic clk, reset;
  int   tests = 0, failed = 0;

  cbus_req_t  [1:0] ireqs_a;  cbus_resp_t [1:0] iresps_a;
  cbus_req_t        oreq_a;   cbus_resp_t       oresp_a;
  logic             busy_a;   logic [0:0]       grant_a;

  cbus_req_t  [3:0] ireqs_b, ireqs_c, ireqs_d;
  cbus_resp_t [3:0] iresps_b, iresps_c, iresps_d;
  cbus_req_t        oreq_b, oreq_c, oreq_d;
  cbus_resp_t       oresp_b, oresp_c, oresp_d;
  logic             busy_b, busy_c, busy_d;
  logic [1:0]       grant_b, grant_c, grant_d;

  cbus_rr_arbiter #(.NUM_INPUTS(2), .ROUND_ROBIN(1), .STARVE_LIMIT(0)) u_a (
    .clk(clk), .reset(reset), .ireqs(ireqs_a), .iresps(iresps_a),
    .oreq(oreq_a), .oresp(oresp_a), .busy(busy_a), .grant_idx(grant_a));
  cbus_rr_arbiter #(.NUM_INPUTS(4), .ROUND_ROBIN(1), .STARVE_LIMIT(0)) u_b (
    .clk(clk), .reset(reset), .ireqs(ireqs_b), .iresps(iresps_b),
    .oreq(oreq_b), .oresp(oresp_b), .busy(busy_b), .grant_idx(grant_b));
  cbus_rr_arbiter #(.NUM_INPUTS(4), .ROUND_ROBIN(0), .STARVE_LIMIT(0)) u_c (
    .clk(clk), .reset(reset), .ireqs(ireqs_c), .iresps(iresps_c),
    .oreq(oreq_c), .oresp(oresp_c), .busy(busy_c), .grant_idx(grant_c));
  cbus_rr_arbiter #(.NUM_INPUTS(4), .ROUND_ROBIN(0), .STARVE_LIMIT(2)) u_d (
    .clk(clk), .reset(reset), .ireqs(ireqs_d), .iresps(iresps_d),
    .oreq(oreq_d), .oresp(oresp_d), .busy(busy_d), .grant_idx(grant_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected grant indices per DUT (a,b,c,d), pushed as stimulus is issued.
  int q0[$], q1[$], q2[$], q3[$];
  logic [3:0] prev_busy = '0;

  task automatic grant_seen(input int d, input int got, input logic [31:0] addr);
    int e;
    e = -1;
    case (d)
      0: if (q0.size() > 0) e = q0.pop_front();
      1: if (q1.size() > 0) e = q1.pop_front();
      2: if (q2.size() > 0) e = q2.pop_front();
      default: if (q3.size() > 0) e = q3.pop_front();
    endcase
    check($sformatf("grant_dut%0d", d), 64'(got), 64'(e));
    check($sformatf("oreq_addr_dut%0d", d), 64'(addr), 64'(32'h1000 + e * 16));
  endtask

  always @(negedge clk) begin
    if (busy_a && !prev_busy[0]) grant_seen(0, int'(grant_a), oreq_a.addr);
    if (busy_b && !prev_busy[1]) grant_seen(1, int'(grant_b), oreq_b.addr);
    if (busy_c && !prev_busy[2]) grant_seen(2, int'(grant_c), oreq_c.addr);
    if (busy_d && !prev_busy[3]) grant_seen(3, int'(grant_d), oreq_d.addr);
    prev_busy <= {busy_d, busy_c, busy_b, busy_a};
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_valid_all(input logic v);
    for (int i = 0; i < 2; i++) ireqs_a[i].valid = v;
    for (int i = 0; i < 4; i++) begin
      ireqs_b[i].valid = v;
      ireqs_c[i].valid = v;
      ireqs_d[i].valid = v;
    end
  endtask

  initial begin
    ireqs_a = '0; ireqs_b = '0; ireqs_c = '0; ireqs_d = '0;
    oresp_a = '0; oresp_b = '0; oresp_c = '0; oresp_d = '0;
    for (int i = 0; i < 2; i++) ireqs_a[i].addr = 32'h1000 + 32'(i * 16);
    for (int i = 0; i < 4; i++) begin
      ireqs_b[i].addr = 32'h1000 + 32'(i * 16);
      ireqs_c[i].addr = 32'h1000 + 32'(i * 16);
      ireqs_d[i].addr = 32'h1000 + 32'(i * 16);
    end

    // Reset held with every request valid.
    reset = 1'b0;
    set_valid_all(1'b1);
    repeat (3) tick();
    check("rst_busy_a", 64'(busy_a), 0);
    check("rst_busy_b", 64'(busy_b), 0);
    check("rst_grant_a", 64'(grant_a), 0);
    check("rst_oreq_valid_a", 64'(oreq_a.valid), 0);
    check("rst_oreq_valid_d", 64'(oreq_d.valid), 0);
    check("rst_iresps_a", 64'(iresps_a), 0);
    set_valid_all(1'b0);
    reset = 1'b1;
    tick();

    // Single request on port 1, 4-cycle transaction.
    ireqs_a[1].valid = 1'b1;
    q0.push_back(1);
    tick();
    check("single_oreq_valid", 64'(oreq_a.valid), 1);
    check("single_grant_idx", 64'(grant_a), 1);
    oresp_a.ready = 1'b1;
    oresp_a.rdata = 32'h5A5A;
    #1;
    check("single_iresp1_rdata", 64'(iresps_a[1].rdata), 64'h5A5A);
    check("single_iresp0_zero", 64'(iresps_a[0]), 0);
    tick(); tick(); tick();
    oresp_a.last = 1'b1;
    check("single_busy_at_last", 64'(busy_a), 1);
    tick();
    check("single_busy_after", 64'(busy_a), 0);
    oresp_a = '0;
    ireqs_a[1].valid = 1'b0;
    tick();

    // RR all-valid on b; fixed on c; fixed+starvation on d. 1-beat transactions.
    for (int i = 0; i < 4; i++) ireqs_b[i].valid = 1'b1;
    ireqs_c[0].valid = 1'b1; ireqs_c[3].valid = 1'b1;
    ireqs_d[0].valid = 1'b1; ireqs_d[3].valid = 1'b1;
    q1 = '{0, 1, 2, 3, 0, 1};
    q2 = '{0, 0, 0, 0, 0, 0};
    q3 = '{0, 0, 3, 0, 0, 3};
    repeat (12) begin
      tick();
      oresp_b.last = busy_b;
      oresp_c.last = busy_c;
      oresp_d.last = busy_d;
    end
    for (int i = 0; i < 4; i++) begin
      ireqs_b[i].valid = 1'b0;
      ireqs_c[i].valid = 1'b0;
      ireqs_d[i].valid = 1'b0;
    end
    repeat (3) begin
      tick();
      oresp_b.last = busy_b;
      oresp_c.last = busy_c;
      oresp_d.last = busy_d;
    end
    check("phase_b_idle", 64'(busy_b), 0);

    // 4-beat burst on port 0 with port 1 waiting; then reset mid-transaction.
    ireqs_a[0].valid = 1'b1;
    ireqs_a[1].valid = 1'b1;
    q0.push_back(0);
    q0.push_back(1);
    tick();
    check("burst_grant0", 64'(grant_a), 0);
    for (int b = 1; b <= 4; b++) begin
      oresp_a.ready = 1'b1;
      oresp_a.rdata = 32'hB000 + 32'(b);
      oresp_a.last  = (b == 4);
      #1;
      check($sformatf("burst_iresp1_zero_b%0d", b), 64'(iresps_a[1]), 0);
      check($sformatf("burst_iresp0_rdata_b%0d", b), 64'(iresps_a[0].rdata), 64'(32'hB000 + b));
      if (b == 4) ireqs_a[0].valid = 1'b0;
      tick();
    end
    oresp_a = '0;
    check("burst_idle_bubble", 64'(busy_a), 0);
    check("burst_iresp1_still_zero", 64'(iresps_a[1]), 0);
    tick();
    check("burst_next_grant1", 64'(grant_a), 1);
    check("burst_next_busy", 64'(busy_a), 1);
    oresp_a.ready = 1'b1;
    oresp_a.rdata = 32'hC001;
    tick();
    oresp_a.rdata = 32'hC002;
    reset = 1'b0;
    #1;
    check("midrst_oreq_quiet", 64'(oreq_a.valid), 0);
    tick();
    check("midrst_busy", 64'(busy_a), 0);
    check("midrst_grant_idx", 64'(grant_a), 0);
    check("midrst_iresps", 64'(iresps_a), 0);
    reset = 1'b1;
    ireqs_a[1].valid = 1'b0;
    oresp_a = '0;
    tick();
    check("postrst_busy", 64'(busy_a), 0);
    tick();

    check("drain_q_a", 64'(q0.size()), 0);
    check("drain_q_b", 64'(q1.size()), 0);
    check("drain_q_c", 64'(q2.size()), 0);
    check("drain_q_d", 64'(q3.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
